// File: rtl/isa_io_initiator_if.sv
// Client request/response and ISA card-side bus signals for isa_io_initiator.
// master = the initiator, slave = client plus bus responder.
interface isa_io_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [19:0] bus_a;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_aen;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic [7:0]  bus_d_in;
  logic        bus_rdy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_d_in, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output bus_a, bus_ior_l, bus_iow_l, bus_aen, bus_d_out, bus_d_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_d_in, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  bus_a, bus_ior_l, bus_iow_l, bus_aen, bus_d_out, bus_d_oe
  );
endinterface

// File: rtl/isa_io_initiator.sv
// ISA 8-bit I/O cycle initiator (IDLE->SETUP->STROBE->WAIT_RDY->HOLD) with IOCHRDY stretching.
// Optional macro ISA_TIMEOUT_EN aborts a stretched strobe after TIMEOUT_CYC cycles of bus_rdy=0.
module isa_io_initiator #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset,
  isa_io_initiator_if.master  io
);

  localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_B = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
`ifdef ISA_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    STROBE   = 3'd2,
    WAIT_RDY = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_n;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n;
  logic          accept_s;
  logic          capture_s;
  logic          timeout_s;
  logic          done_s;
  logic          strobe_n_s;

  logic          write_r;
  logic [7:0]    data_r;
  logic          timeout_r;
  logic          req_ready_r;
  logic          rsp_valid_r;
  logic [7:0]    rsp_rdata_r;
  logic          rsp_timeout_r;
  logic [19:0]   bus_a_r;
  logic          bus_ior_l_r;
  logic          bus_iow_l_r;
  logic          bus_aen_r;
  logic [7:0]    bus_d_out_r;
  logic          bus_d_oe_r;

  // State register and per-state cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; the counter restarts on every state change so it never wraps
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r + CNT_ONE;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = CNT_ZERO;
        if (io.req_valid) begin
          accept_s = 1'b1;
          state_n  = SETUP;
        end else begin
          state_n  = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_n = STROBE;
          cnt_n   = CNT_ZERO;
        end else begin
          state_n = SETUP;
        end
      end
      STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          cnt_n = CNT_ZERO;
          if (io.bus_rdy) begin
            capture_s = 1'b1;
            state_n   = HOLD;
          end else begin
            state_n   = WAIT_RDY;
          end
        end else begin
          state_n = STROBE;
        end
      end
      WAIT_RDY: begin
        if (io.bus_rdy) begin
          capture_s = 1'b1;
          state_n   = HOLD;
          cnt_n     = CNT_ZERO;
        end else begin
`ifdef ISA_TIMEOUT_EN
          if (cnt_r == TIMEOUT_LAST) begin
            timeout_s = 1'b1;
            state_n   = HOLD;
            cnt_n     = CNT_ZERO;
          end else begin
            state_n   = WAIT_RDY;
          end
`else
          state_n = WAIT_RDY;
          cnt_n   = CNT_ZERO;
`endif
        end
      end
      HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          done_s  = 1'b1;
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
      end
    endcase
  end

  assign strobe_n_s = (state_n == STROBE) || (state_n == WAIT_RDY);

  // Strobes, AEN and ready are registered from the next state so they change with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_r <= 1'b1;
      bus_aen_r   <= 1'b1;
      bus_ior_l_r <= 1'b1;
      bus_iow_l_r <= 1'b1;
    end else begin
      req_ready_r <= (state_n == IDLE);
      bus_aen_r   <= (state_n == IDLE);
      bus_ior_l_r <= ~(strobe_n_s & ~write_r);
      bus_iow_l_r <= ~(strobe_n_s & write_r);
    end
  end

  // Transaction capture: address, direction and write data live from accept through HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r     <= 1'b0;
      timeout_r   <= 1'b0;
      bus_a_r     <= 20'h00000;
      bus_d_out_r <= 8'h00;
      bus_d_oe_r  <= 1'b0;
    end else if (accept_s) begin
      write_r     <= io.req_write;
      timeout_r   <= 1'b0;
      bus_a_r     <= {4'h0, io.req_addr};
      bus_d_out_r <= io.req_write ? io.req_wdata : 8'h00;
      bus_d_oe_r  <= io.req_write;
    end else if (state_n == IDLE) begin
      write_r     <= write_r;
      timeout_r   <= timeout_r;
      bus_a_r     <= 20'h00000;
      bus_d_out_r <= 8'h00;
      bus_d_oe_r  <= 1'b0;
    end else begin
      write_r     <= write_r;
      timeout_r   <= timeout_r | timeout_s;
      bus_a_r     <= bus_a_r;
      bus_d_out_r <= bus_d_out_r;
      bus_d_oe_r  <= bus_d_oe_r;
    end
  end

  // Read-data capture on the cycle bus_rdy is seen high at the end of the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= 8'h00;
    end else if (capture_s) begin
      data_r <= io.bus_d_in;
    end else if (timeout_s) begin
      data_r <= 8'hFF;
    end else begin
      data_r <= data_r;
    end
  end

  // Response pulse; data and timeout flag hold until the next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 8'h00;
      rsp_timeout_r <= 1'b0;
    end else if (done_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= timeout_r ? 8'hFF : (write_r ? 8'h00 : data_r);
      rsp_timeout_r <= timeout_r;
    end else begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  assign io.req_ready = req_ready_r;
  assign io.rsp_valid = rsp_valid_r;
  assign io.rsp_rdata = rsp_rdata_r;
`ifdef ISA_TIMEOUT_EN
  assign io.rsp_timeout = rsp_timeout_r;
`else
  assign io.rsp_timeout = 1'b0;
`endif
  assign io.bus_a     = bus_a_r;
  assign io.bus_ior_l = bus_ior_l_r;
  assign io.bus_iow_l = bus_iow_l_r;
  assign io.bus_aen   = bus_aen_r;
  assign io.bus_d_out = bus_d_out_r;
  assign io.bus_d_oe  = bus_d_oe_r;

endmodule

// File: tb/tb_isa_io_initiator.sv
// Scoreboard bench for isa_io_initiator: per-scenario tasks measure strobe/AEN/response timing.
module tb_isa_io_initiator;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] resp_byte;
  always #5 clk = ~clk;

  isa_io_initiator_if bus_if();
  assign bus_if.bus_d_in = bus_if.bus_ior_l ? 8'hEE : resp_byte;

  isa_io_initiator dut (.clk(clk), .reset(reset), .io(bus_if));

  typedef struct packed { logic [7:0] rdata; logic to; } rsp_t;
  rsp_t exp_q[$];
  rsp_t got_q[$];
  int pass_n = 0;
  int total_n = 0;

  int ob_ior_first, ob_ior_cnt, ob_iow_first, ob_iow_cnt;
  int ob_aen_first, ob_aen_last, ob_doe_cnt, ob_rsp_cyc, ob_rsp_cnt;
  logic [19:0] ob_a1;
  logic [7:0]  ob_dout1;
  logic        ob_ready1;

  task automatic push_exp(input logic [7:0] d, input logic t);
    rsp_t e;
    e.rdata = d;
    e.to = t;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  // Runs cycles 1..n after an accept, recording bus timing and responses
  task automatic observe(input int n, input int rlo, input int rhi, input int byte_cyc, input logic [7:0] good);
    rsp_t g;
    ob_ior_first = -1; ob_ior_cnt = 0; ob_iow_first = -1; ob_iow_cnt = 0;
    ob_aen_first = -1; ob_aen_last = -1; ob_doe_cnt = 0; ob_rsp_cyc = -1; ob_rsp_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      bus_if.bus_rdy = (k >= rlo && k <= rhi) ? 1'b0 : 1'b1;
      resp_byte = (byte_cyc == 0 || k == byte_cyc) ? good : 8'h11;
      @(negedge clk);
      if (k == 1) begin
        ob_a1 = bus_if.bus_a; ob_dout1 = bus_if.bus_d_out; ob_ready1 = bus_if.req_ready;
      end
      if (!bus_if.bus_ior_l) begin if (ob_ior_first < 0) ob_ior_first = k; ob_ior_cnt++; end
      if (!bus_if.bus_iow_l) begin if (ob_iow_first < 0) ob_iow_first = k; ob_iow_cnt++; end
      if (!bus_if.bus_aen) begin if (ob_aen_first < 0) ob_aen_first = k; ob_aen_last = k; end
      if (bus_if.bus_d_oe) ob_doe_cnt++;
      if (bus_if.rsp_valid) begin
        if (ob_rsp_cnt == 0) ob_rsp_cyc = k;
        ob_rsp_cnt++;
        g.rdata = bus_if.rsp_rdata; g.to = bus_if.rsp_timeout;
        got_q.push_back(g);
      end
      @(posedge clk);
      #1;
    end
    bus_if.bus_rdy = 1'b1;
    resp_byte = 8'h06;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_addr = 16'h0000;
    bus_if.req_wdata = 8'h00; bus_if.bus_rdy = 1'b1; resp_byte = 8'h06;
    repeat (3) @(negedge clk);
    total_n++;
    if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_timeout} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_client: got %b", {bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_timeout});
    else pass_n++;
    total_n++;
    if ({bus_if.bus_a, bus_if.bus_ior_l, bus_if.bus_iow_l, bus_if.bus_aen, bus_if.bus_d_out, bus_if.bus_d_oe} !== {20'h00000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0})
      $display("FAIL reset_bus: got a=%h ior=%b iow=%b aen=%b d=%h oe=%b", bus_if.bus_a, bus_if.bus_ior_l,
               bus_if.bus_iow_l, bus_if.bus_aen, bus_if.bus_d_out, bus_if.bus_d_oe);
    else pass_n++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_n++;
    if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.bus_aen, bus_if.bus_ior_l, bus_if.bus_iow_l} !== 5'b10111)
      $display("FAIL idle_after_reset: got %b expected 10111", {bus_if.req_ready, bus_if.rsp_valid, bus_if.bus_aen, bus_if.bus_ior_l, bus_if.bus_iow_l});
    else pass_n++;
  endtask

  task automatic test_write;
    rsp_t e, g;
    got_q.delete();
    push_exp(8'h00, 1'b0);
    issue(1'b1, 16'h0388, 8'h20);
    observe(14, 0, -1, 0, 8'h06);
    total_n++; if (ob_ready1 !== 1'b0) $display("FAIL wr_ready_busy: got %b expected 0", ob_ready1); else pass_n++;
    total_n++; if (ob_a1 !== 20'h00388) $display("FAIL wr_addr: got %h expected 00388", ob_a1); else pass_n++;
    total_n++; if (ob_dout1 !== 8'h20) $display("FAIL wr_dout: got %h expected 20", ob_dout1); else pass_n++;
    total_n++; if (ob_aen_first !== 1 || ob_aen_last !== 10) $display("FAIL wr_aen: got %0d-%0d expected 1-10", ob_aen_first, ob_aen_last); else pass_n++;
    total_n++; if (ob_iow_first !== 3 || ob_iow_cnt !== 6) $display("FAIL wr_iow: got start %0d len %0d expected 3/6", ob_iow_first, ob_iow_cnt); else pass_n++;
    total_n++; if (ob_ior_cnt !== 0) $display("FAIL wr_ior: got %0d low cycles expected 0", ob_ior_cnt); else pass_n++;
    total_n++; if (ob_doe_cnt !== 10) $display("FAIL wr_doe: got %0d cycles expected 10", ob_doe_cnt); else pass_n++;
    total_n++; if (ob_rsp_cyc !== 11 || ob_rsp_cnt !== 1) $display("FAIL wr_rsp: got cycle %0d count %0d expected 11/1", ob_rsp_cyc, ob_rsp_cnt); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL wr_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL wr_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
  endtask

  task automatic test_read;
    rsp_t e, g;
    got_q.delete();
    push_exp(8'h06, 1'b0);
    issue(1'b0, 16'h0389, 8'h00);
    observe(14, 0, -1, 0, 8'h06);
    total_n++; if (ob_a1 !== 20'h00389) $display("FAIL rd_addr: got %h expected 00389", ob_a1); else pass_n++;
    total_n++; if (ob_ior_first !== 3 || ob_ior_cnt !== 6) $display("FAIL rd_ior: got start %0d len %0d expected 3/6", ob_ior_first, ob_ior_cnt); else pass_n++;
    total_n++; if (ob_iow_cnt !== 0 || ob_doe_cnt !== 0) $display("FAIL rd_no_drive: got iow %0d oe %0d expected 0/0", ob_iow_cnt, ob_doe_cnt); else pass_n++;
    total_n++; if (ob_rsp_cyc !== 11 || ob_rsp_cnt !== 1) $display("FAIL rd_rsp: got cycle %0d count %0d expected 11/1", ob_rsp_cyc, ob_rsp_cnt); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL rd_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL rd_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
    total_n++; if (bus_if.rsp_rdata !== 8'h06) $display("FAIL rd_hold: got %h expected 06", bus_if.rsp_rdata); else pass_n++;
  endtask

  task automatic test_stretch;
    rsp_t e, g;
    got_q.delete();
    push_exp(8'h5A, 1'b0);
    issue(1'b0, 16'h0201, 8'h00);
    observe(24, 3, 17, 18, 8'h5A);
    total_n++; if (ob_ior_first !== 3 || ob_ior_cnt !== 16) $display("FAIL st_ior: got start %0d len %0d expected 3/16", ob_ior_first, ob_ior_cnt); else pass_n++;
    total_n++; if (ob_rsp_cyc !== 21 || ob_rsp_cnt !== 1) $display("FAIL st_rsp: got cycle %0d count %0d expected 21/1", ob_rsp_cyc, ob_rsp_cnt); else pass_n++;
    total_n++; if (ob_aen_last !== 20) $display("FAIL st_aen: got last low %0d expected 20", ob_aen_last); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL st_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL st_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
  endtask

  task automatic test_timeout;
    rsp_t e, g;
    got_q.delete();
`ifdef ISA_TIMEOUT_EN
    push_exp(8'hFF, 1'b1);
    issue(1'b0, 16'h0210, 8'h00);
    observe(275, 1, 100000, 0, 8'h06);
    total_n++; if (ob_ior_first !== 3 || ob_ior_cnt !== 262) $display("FAIL to_ior: got start %0d len %0d expected 3/262", ob_ior_first, ob_ior_cnt); else pass_n++;
    total_n++; if (ob_rsp_cyc !== 267 || ob_rsp_cnt !== 1) $display("FAIL to_rsp: got cycle %0d count %0d expected 267/1", ob_rsp_cyc, ob_rsp_cnt); else pass_n++;
    total_n++; if (ob_aen_last !== 266) $display("FAIL to_aen: got last low %0d expected 266", ob_aen_last); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL to_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL to_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
`else
    issue(1'b0, 16'h0210, 8'h00);
    observe(1000, 1, 100000, 0, 8'h06);
    total_n++; if (ob_rsp_cnt !== 0) $display("FAIL nto_rsp: got %0d responses expected 0", ob_rsp_cnt); else pass_n++;
    total_n++; if (ob_ior_cnt !== 998) $display("FAIL nto_ior: got %0d low cycles expected 998", ob_ior_cnt); else pass_n++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    e.rdata = 8'h00; e.to = 1'b0;
    g = e;
`endif
  endtask

  task automatic test_back_to_back;
    rsp_t e, g;
    logic [15:0] addrs [3];
    logic        wrs   [3];
    logic [7:0]  wds   [3];
    int acc_cyc [$];
    int rsp_cyc [$];
    int idx = 0;
    int aen_ok = 0;
    int overlap = 0;
    logic will_acc;
    addrs[0] = 16'h0300; wrs[0] = 1'b1; wds[0] = 8'hA1;
    addrs[1] = 16'h0301; wrs[1] = 1'b0; wds[1] = 8'h00;
    addrs[2] = 16'h0302; wrs[2] = 1'b1; wds[2] = 8'h5C;
    got_q.delete();
    push_exp(8'h00, 1'b0); push_exp(8'h06, 1'b0); push_exp(8'h00, 1'b0);
    bus_if.bus_rdy = 1'b1; resp_byte = 8'h06;
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_write = wrs[0]; bus_if.req_addr = addrs[0]; bus_if.req_wdata = wds[0];
    for (int k = 0; k < 40; k++) begin
      if (!bus_if.bus_ior_l && !bus_if.bus_iow_l) overlap++;
      if (bus_if.rsp_valid) begin
        rsp_cyc.push_back(k);
        if (bus_if.bus_aen) aen_ok++;
        g.rdata = bus_if.rsp_rdata; g.to = bus_if.rsp_timeout;
        got_q.push_back(g);
      end
      will_acc = bus_if.req_valid && bus_if.req_ready;
      @(posedge clk);
      #1;
      if (will_acc) begin
        acc_cyc.push_back(k);
        idx++;
        if (idx < 3) begin
          bus_if.req_write = wrs[idx]; bus_if.req_addr = addrs[idx]; bus_if.req_wdata = wds[idx];
        end else begin
          bus_if.req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus_if.req_valid = 1'b0;
    total_n++;
    if (acc_cyc.size() !== 3) $display("FAIL b2b_accepts: got %0d expected 3", acc_cyc.size());
    else if (acc_cyc[0] !== 0 || acc_cyc[1] !== 11 || acc_cyc[2] !== 22)
      $display("FAIL b2b_accepts: got %0d,%0d,%0d expected 0,11,22", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    else pass_n++;
    total_n++;
    if (rsp_cyc.size() !== 3) $display("FAIL b2b_rsp: got %0d pulses expected 3", rsp_cyc.size());
    else if (rsp_cyc[0] !== 11 || rsp_cyc[1] !== 22 || rsp_cyc[2] !== 33)
      $display("FAIL b2b_rsp: got %0d,%0d,%0d expected 11,22,33", rsp_cyc[0], rsp_cyc[1], rsp_cyc[2]);
    else pass_n++;
    total_n++; if (aen_ok !== 3) $display("FAIL b2b_aen: got %0d idle-aen responses expected 3", aen_ok); else pass_n++;
    total_n++; if (overlap !== 0) $display("FAIL b2b_overlap: got %0d expected 0", overlap); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL b2b_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL b2b_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
  endtask

  task automatic test_reset_mid;
    rsp_t e, g;
    got_q.delete();
    issue(1'b1, 16'h0388, 8'h77);
    repeat (3) @(posedge clk);
    #1;
    total_n++; if (bus_if.bus_iow_l !== 1'b0) $display("FAIL rm_in_strobe: got iow_l %b expected 0", bus_if.bus_iow_l); else pass_n++;
    #2 reset = 1'b1;
    #1;
    total_n++;
    if ({bus_if.bus_ior_l, bus_if.bus_iow_l, bus_if.bus_aen, bus_if.bus_d_oe, bus_if.req_ready, bus_if.rsp_valid} !== 6'b111010)
      $display("FAIL rm_idle: got %b expected 111010", {bus_if.bus_ior_l, bus_if.bus_iow_l, bus_if.bus_aen, bus_if.bus_d_oe, bus_if.req_ready, bus_if.rsp_valid});
    else pass_n++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    observe(15, 0, -1, 0, 8'h06);
    total_n++; if (ob_rsp_cnt !== 0 || ob_aen_first !== -1) $display("FAIL rm_quiet: got rsp %0d aen_low %0d expected 0/-1", ob_rsp_cnt, ob_aen_first); else pass_n++;
    got_q.delete();
    push_exp(8'h06, 1'b0);
    issue(1'b0, 16'h0389, 8'h00);
    observe(14, 0, -1, 0, 8'h06);
    total_n++; if (ob_rsp_cyc !== 11 || ob_ior_cnt !== 6) $display("FAIL rm_recover: got rsp %0d ior %0d expected 11/6", ob_rsp_cyc, ob_ior_cnt); else pass_n++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total_n++;
      if (got_q.size() == 0) $display("FAIL rm_sb: got no response expected %h/%b", e.rdata, e.to);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL rm_sb: got %h/%b expected %h/%b", g.rdata, g.to, e.rdata, e.to); else pass_n++; end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stretch();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
